// File: rtl/common_bus_arbiter_if.sv
// common_bus_arbiter_if: groups the request/grant signals shared by the
// bus masters and the common_bus_arbiter.
//
// Handshake: req[i] is a level request held by master i until it is served.
// grant[i] is a registered one-hot grant that stays high while master i owns
// the bus. A master releases the bus by dropping req[i]. The arbiter
// withdraws grant for exactly one dead cycle between any two owners.
// lock[i] is looked at only while master i is the owner, and blocks forced
// release. owner_id selects the bus driver mux. bus_valid mirrors |grant.
// preempt flags the dead cycle that follows a forced release.
// dbg_state exposes the arbiter FSM state: 0=IDLE, 1=GRANT, 2=TURNAROUND.
interface common_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    owner_id;
    logic               bus_valid;
    logic               preempt;
    logic [1:0]         dbg_state;

    // Arbiter side.
    modport slave (
        input  req,
        input  lock,
        output grant,
        output owner_id,
        output bus_valid,
        output preempt,
        output dbg_state
    );

    // Requesting-master side.
    modport master (
        output req,
        output lock,
        input  grant,
        input  owner_id,
        input  bus_valid,
        input  preempt,
        input  dbg_state
    );
endinterface

// File: rtl/common_bus_arbiter.sv
// common_bus_arbiter: shares the 8-bit common data bus among NUM_REQ masters.
// One owner at a time, a one-cycle dead turnaround between owners, and forced
// release of an owner that holds the bus for MAX_HOLD cycles while someone
// else is waiting, unless that owner asserts lock.
//
// Build option: BUS_ARB_FIXED_PRI_EN selects fixed priority, where the lowest
// index wins. When it is not defined, the arbiter uses round-robin starting
// after the last owner.
module common_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    common_bus_arbiter_if.slave  bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [NUM_REQ-1:0]  grant_q,   grant_d;
    logic [ID_W-1:0]     owner_q,   owner_d;
    logic                valid_q,   valid_d;
    logic                preempt_q, preempt_d;
    logic [HOLD_W-1:0]   hold_q,    hold_d;
    logic [ID_W-1:0]     winner;
    logic                any_req;
    logic                owner_req;
    logic                others_req;

`ifdef BUS_ARB_FIXED_PRI_EN
    // Fixed priority: the lowest set index wins.
    function automatic logic [ID_W-1:0] arbitrate(input logic [NUM_REQ-1:0] r);
        logic [ID_W-1:0] k;
        arbitrate = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = ID_W'(i);
            if (r[k]) begin
                arbitrate = k;
            end
        end
    endfunction
`else
    logic [ID_W-1:0] last_q, last_d;

    // Round-robin: the search starts just after the last owner and wraps.
    function automatic logic [ID_W-1:0] arbitrate(input logic [NUM_REQ-1:0] r,
                                                  input logic [ID_W-1:0]    last);
        logic            found;
        logic [ID_W-1:0] k;
        arbitrate = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = ID_W'((int'(last) + 1 + i) % NUM_REQ);
            if (!found && r[k]) begin
                arbitrate = k;
                found     = 1'b1;
            end
        end
    endfunction
`endif

    // Arbitration inputs. Only the owner's bits of req and lock steer a GRANT
    // decision, except for the pre-emption check on the saturated count.
    always_comb begin
`ifdef BUS_ARB_FIXED_PRI_EN
        winner = arbitrate(bus.req);
`else
        winner = arbitrate(bus.req, last_q);
`endif
        any_req    = |bus.req;
        owner_req  = bus.req[owner_q];
        others_req = |(bus.req & ~grant_q);
    end

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        hold_d    = hold_q;
`ifndef BUS_ARB_FIXED_PRI_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE, S_TURN: begin
                if (any_req) begin
                    state_d = S_GRANT;
                    grant_d = NUM_REQ'(1) << winner;
                    owner_d = winner;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    owner_d = '0;
                    valid_d = 1'b0;
                end
            end
            S_GRANT: begin
                // A normal release takes precedence over pre-emption. The lock
                // bit is sampled at the same edge as the saturated count, so if
                // lock rises on that cycle, it wins.
                if (!owner_req ||
                    (hold_q == HOLD_LAST && !bus.lock[owner_q] && others_req)) begin
                    state_d   = S_TURN;
                    grant_d   = '0;
                    owner_d   = '0;
                    valid_d   = 1'b0;
                    preempt_d = owner_req;
`ifndef BUS_ARB_FIXED_PRI_EN
                    last_d    = owner_q;
`endif
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                owner_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    // State and registered outputs. Reset clears the bus immediately, even in
    // the middle of a grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
`ifndef BUS_ARB_FIXED_PRI_EN
            last_q    <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
`ifndef BUS_ARB_FIXED_PRI_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.grant     = grant_q;
    assign bus.owner_id  = owner_q;
    assign bus.bus_valid = valid_q;
    assign bus.preempt   = preempt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_common_bus_arbiter.sv
// tb_common_bus_arbiter: table-driven vectors for common_bus_arbiter
// (NUM_REQ=4, MAX_HOLD=8) plus a hand-written sequence for asynchronous reset.
module tb_common_bus_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 8;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] grant;
        logic [1:0] owner;
        logic       valid;
        logic       pre;
        logic [1:0] state;
    } vec_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GRNT = 2'd1;
    localparam logic [1:0] TURN = 2'd2;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[$];

    common_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    common_bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    // Clock and reset.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                       input logic [3:0] grant, input logic [1:0] owner,
                       input logic valid, input logic pre, input logic [1:0] state);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.grant = grant;
        v.owner = owner; v.valid = valid; v.pre = pre; v.state = state;
        vecs.push_back(v);
    endtask

    task automatic add_rst();
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, IDLE);
    endtask

    task automatic add_gnt(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] owner);
        logic [3:0] g;
        g = 4'b0001 << owner;
        add(1'b0, req, lock, g, owner, 1'b1, 1'b0, GRNT);
    endtask

    task automatic add_gap(input logic [3:0] req, input logic [3:0] lock, input logic pre, input logic [1:0] state);
        add(1'b0, req, lock, 4'b0000, 2'd0, 1'b0, pre, state);
    endtask

    // Compare every registered output after one edge.
    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, " grant"},     32'(bus_if.grant),     32'(v.grant));
        chk({tag, " owner_id"},  32'(bus_if.owner_id),  32'(v.owner));
        chk({tag, " bus_valid"}, 32'(bus_if.bus_valid), 32'(v.valid));
        chk({tag, " preempt"},   32'(bus_if.preempt),   32'(v.pre));
        chk({tag, " state"},     32'(bus_if.dbg_state), 32'(v.state));
    endtask

    // Stimulus tables.
    task automatic build_vectors();
        logic [1:0] o;
        // Single request, release, and return to IDLE.
        add_rst();
        add_gnt(4'b0001, 4'b0000, 2'd0);
        add_gap(4'b0000, 4'b0000, 1'b0, TURN);
        add_gap(4'b0000, 4'b0000, 1'b0, IDLE);
        // All four requesting: forced rotation every 8 cycles with a 1-cycle gap.
        add_rst();
        for (int k = 0; k < 5; k++) begin
`ifdef BUS_ARB_FIXED_PRI_EN
            o = 2'd0;
`else
            o = 2'(k % 4);
`endif
            for (int c = 0; c < (k == 4 ? 1 : MAX_HOLD); c++) add_gnt(4'b1111, 4'b0000, o);
            if (k < 4) add_gap(4'b1111, 4'b0000, 1'b1, TURN);
        end
        // A locked owner keeps the bus past MAX_HOLD; on release, the other master gets the bus after one gap.
        add_rst();
        for (int c = 0; c < 12; c++) add_gnt(4'b0011, 4'b0001, 2'd0);
        add_gap(4'b0010, 4'b0000, 1'b0, TURN);
        add_gnt(4'b0010, 4'b0000, 2'd1);
        add_gap(4'b0000, 4'b0000, 1'b0, TURN);
        add_gap(4'b0000, 4'b0000, 1'b0, IDLE);
        // A lone requester is never pre-empted.
        add_rst();
        for (int c = 0; c < 20; c++) add_gnt(4'b0100, 4'b0000, 2'd2);
        add_gap(4'b0000, 4'b0000, 1'b0, TURN);
        add_gap(4'b0000, 4'b0000, 1'b0, IDLE);
        // If the owner drops req on the edge where the count saturates, this is a normal release.
        add_rst();
        for (int c = 0; c < MAX_HOLD; c++) add_gnt(4'b0011, 4'b0000, 2'd0);
        add_gap(4'b0010, 4'b0000, 1'b0, TURN);
        add_gnt(4'b0010, 4'b0000, 2'd1);
        // If lock rises on the edge where the count saturates, lock wins. When lock drops, pre-emption follows.
        add_rst();
        for (int c = 0; c < MAX_HOLD; c++) add_gnt(4'b0011, 4'b0000, 2'd0);
        add_gnt(4'b0011, 4'b0001, 2'd0);
        add_gnt(4'b0011, 4'b0001, 2'd0);
        add_gap(4'b0011, 4'b0000, 1'b1, TURN);
        add_rst();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_if.req  = '0;
        bus_if.lock = '0;
        build_vectors();
        repeat (2) @(posedge clock);
        #1;
        chk("reset grant",     32'(bus_if.grant),     32'h0);
        chk("reset bus_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("reset state",     32'(bus_if.dbg_state), 32'(IDLE));

        // Table-driven run: drive #1 after an edge, then check after the next edge.
        foreach (vecs[i]) begin
            reset       = vecs[i].rst;
            bus_if.req  = vecs[i].req;
            bus_if.lock = vecs[i].lock;
            @(posedge clock);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset in the middle of a grant to owner 2. Outputs must clear before any clock edge.
        reset      = 1'b0;
        bus_if.req = 4'b0100;
        @(posedge clock); #1;
        chk("mid grant",    32'(bus_if.grant),    32'b0100);
        chk("mid owner_id", 32'(bus_if.owner_id), 32'd2);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("async grant",     32'(bus_if.grant),     32'h0);
        chk("async bus_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("async owner_id",  32'(bus_if.owner_id),  32'h0);
        bus_if.req = 4'b0101;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post reset grant",     32'(bus_if.grant),     32'b0001);
        chk("post reset owner_id",  32'(bus_if.owner_id),  32'd0);
        chk("post reset bus_valid", 32'(bus_if.bus_valid), 32'h1);
        bus_if.req = '0;
        repeat (3) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
